// File: rtl/alu_cmd_sequencer.sv
// Command buffer and in-order result return in front of a fixed-latency ALU.
// Optional build macro ALU_SEQ_STATS_EN adds saturating stat_issued/stat_completed counters.
module alu_cmd_sequencer #(
    parameter int DATA_W         = 8,
    parameter int CMD_DEPTH      = 4,
    parameter int RES_DEPTH      = 4,
    parameter int RESULT_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_A,
    input  logic [DATA_W-1:0] cmd_B,
    input  logic              cmd_a_en,
    input  logic              cmd_b_en,
    input  logic [2:0]        cmd_a_op,
    input  logic [1:0]        cmd_b_op,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              a_en,
    output logic              b_en,
    output logic [2:0]        a_op,
    output logic [1:0]        b_op,
    output logic              ALU_en,
    input  logic [DATA_W-1:0] C,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]       stat_issued,
    output logic [15:0]       stat_completed
`endif
);

    localparam int CPTR_W = $clog2(CMD_DEPTH);
    localparam int CCNT_W = CPTR_W + 1;
    localparam int RPTR_W = $clog2(RES_DEPTH);
    localparam int RCNT_W = RPTR_W + 1;
    localparam int CMD_W  = 2 * DATA_W + 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic int popcount_f(input logic [RESULT_LATENCY-1:0] v);
        int n;
        n = 32'sd0;
        for (int i = 0; i < RESULT_LATENCY; i++) begin
            if (v[i]) n = n + 32'sd1;
        end
        return n;
    endfunction

    logic [CMD_W-1:0]          cmd_mem_r [CMD_DEPTH];
    logic [CPTR_W-1:0]         cmd_wr_ptr_r;
    logic [CPTR_W-1:0]         cmd_rd_ptr_r;
    logic [CCNT_W-1:0]         cmd_count_r;
    logic [CCNT_W-1:0]         cmd_count_nxt_s;
    logic [DATA_W-1:0]         res_mem_r [RES_DEPTH];
    logic [RPTR_W-1:0]         res_wr_ptr_r;
    logic [RPTR_W-1:0]         res_rd_ptr_r;
    logic [RCNT_W-1:0]         res_count_r;
    logic [RCNT_W-1:0]         res_count_nxt_s;
    logic [RESULT_LATENCY-1:0] vld_pipe_r;
    logic [RESULT_LATENCY-1:0] vld_pipe_nxt_s;
    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [CMD_W-1:0]          cmd_head_s;
    logic                      cmd_push_s;
    logic                      issue_s;
    logic                      capture_s;
    logic                      res_pop_s;
    logic                      cmd_avail_nxt_s;
    logic                      inflight_nxt_s;
    logic                      credit_nxt_s;

    assign cmd_ready  = (cmd_count_r != CCNT_W'(CMD_DEPTH));
    assign res_valid  = (res_count_r != {RCNT_W{1'b0}});
    assign res_data   = res_mem_r[res_rd_ptr_r];
    assign busy       = (state_r != ST_IDLE) || res_valid;
    assign cmd_head_s = cmd_mem_r[cmd_rd_ptr_r];
    assign cmd_push_s = cmd_valid && cmd_ready;
    assign issue_s    = (state_r == ST_ISSUE) && (cmd_count_r != {CCNT_W{1'b0}});
    assign capture_s  = vld_pipe_r[RESULT_LATENCY-1];
    assign res_pop_s  = res_valid && res_ready;

    // Occupancy of both FIFOs for the coming cycle
    always_comb begin
        cmd_count_nxt_s = cmd_count_r;
        res_count_nxt_s = res_count_r;
        case ({cmd_push_s, issue_s})
            2'b10:   cmd_count_nxt_s = cmd_count_r + CCNT_W'(1'b1);
            2'b01:   cmd_count_nxt_s = cmd_count_r - CCNT_W'(1'b1);
            default: cmd_count_nxt_s = cmd_count_r;
        endcase
        case ({capture_s, res_pop_s})
            2'b10:   res_count_nxt_s = res_count_r + RCNT_W'(1'b1);
            2'b01:   res_count_nxt_s = res_count_r - RCNT_W'(1'b1);
            default: res_count_nxt_s = res_count_r;
        endcase
    end

    // Valid pipe shift; stage 0 is loaded from the op currently on the ALU port
    always_comb begin
        vld_pipe_nxt_s    = {RESULT_LATENCY{1'b0}};
        vld_pipe_nxt_s[0] = ALU_en;
        for (int i = 1; i < RESULT_LATENCY; i++) begin
            vld_pipe_nxt_s[i] = vld_pipe_r[i-1];
        end
    end

    // The op driving ALU_en is in flight too, so it consumes a credit
    assign cmd_avail_nxt_s = (cmd_count_nxt_s != {CCNT_W{1'b0}});
    assign inflight_nxt_s  = (vld_pipe_nxt_s != {RESULT_LATENCY{1'b0}}) || issue_s;
    assign credit_nxt_s    = (popcount_f(vld_pipe_nxt_s) + (issue_s ? 32'sd1 : 32'sd0)
                              + int'(res_count_nxt_s)) < RES_DEPTH;

    // Next state follows next-cycle contents so ISSUE always means "may issue now"
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_ISSUE, ST_STALL, ST_DRAIN: begin
                if (cmd_avail_nxt_s) begin
                    state_nxt_s = credit_nxt_s ? ST_ISSUE : ST_STALL;
                end else if (inflight_nxt_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, pointers, counts and valid pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cmd_wr_ptr_r <= {CPTR_W{1'b0}};
            cmd_rd_ptr_r <= {CPTR_W{1'b0}};
            cmd_count_r  <= {CCNT_W{1'b0}};
            res_wr_ptr_r <= {RPTR_W{1'b0}};
            res_rd_ptr_r <= {RPTR_W{1'b0}};
            res_count_r  <= {RCNT_W{1'b0}};
            vld_pipe_r   <= {RESULT_LATENCY{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            cmd_count_r <= cmd_count_nxt_s;
            res_count_r <= res_count_nxt_s;
            vld_pipe_r  <= vld_pipe_nxt_s;
            if (cmd_push_s) cmd_wr_ptr_r <= cmd_wr_ptr_r + CPTR_W'(1'b1);
            if (issue_s)    cmd_rd_ptr_r <= cmd_rd_ptr_r + CPTR_W'(1'b1);
            if (capture_s)  res_wr_ptr_r <= res_wr_ptr_r + RPTR_W'(1'b1);
            if (res_pop_s)  res_rd_ptr_r <= res_rd_ptr_r + RPTR_W'(1'b1);
        end
    end

    // FIFO storage; a capture landing in a reset cycle is dropped
    always_ff @(posedge clk) begin
        if (!rst && cmd_push_s) begin
            cmd_mem_r[cmd_wr_ptr_r] <= {cmd_A, cmd_B, cmd_a_en, cmd_b_en, cmd_a_op, cmd_b_op};
        end
        if (!rst && capture_s) begin
            res_mem_r[res_wr_ptr_r] <= C;
        end
    end

    // ALU port registers; operands hold after the issue cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            A      <= {DATA_W{1'b0}};
            B      <= {DATA_W{1'b0}};
            a_en   <= 1'b0;
            b_en   <= 1'b0;
            a_op   <= 3'd0;
            b_op   <= 2'd0;
            ALU_en <= 1'b0;
        end else begin
            ALU_en <= issue_s;
            if (issue_s) begin
                {A, B, a_en, b_en, a_op, b_op} <= cmd_head_s;
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    // Saturating issue/completion counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued    <= 16'h0000;
            stat_completed <= 16'h0000;
        end else begin
            if (ALU_en && (stat_issued != 16'hFFFF)) begin
                stat_issued <= stat_issued + 16'h0001;
            end
            if (res_pop_s && (stat_completed != 16'hFFFF)) begin
                stat_completed <= stat_completed + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a latency-1 ALU model.
// Stats checks are compiled in only when ALU_SEQ_STATS_EN is defined.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_A;
    logic [7:0] cmd_B;
    logic       cmd_a_en;
    logic       cmd_b_en;
    logic [2:0] cmd_a_op;
    logic [1:0] cmd_b_op;
    logic [7:0] A;
    logic [7:0] B;
    logic       a_en;
    logic       b_en;
    logic [2:0] a_op;
    logic [1:0] b_op;
    logic       ALU_en;
    logic [7:0] C = 8'h00;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       busy;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_completed;
`endif

    int total = 0;
    int bad   = 0;

    alu_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_A(cmd_A), .cmd_B(cmd_B),
        .cmd_a_en(cmd_a_en), .cmd_b_en(cmd_b_en),
        .cmd_a_op(cmd_a_op), .cmd_b_op(cmd_b_op),
        .A(A), .B(B), .a_en(a_en), .b_en(b_en), .a_op(a_op), .b_op(b_op),
        .ALU_en(ALU_en), .C(C),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
`ifdef ALU_SEQ_STATS_EN
        , .stat_issued(stat_issued), .stat_completed(stat_completed)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic aen, input logic ben,
                                         input logic [2:0] aop, input logic [1:0] bop);
        if (aen) begin
            case (aop)
                3'd0:    return a + b;
                3'd1:    return a - b;
                default: return a ^ b;
            endcase
        end else if (ben) begin
            case (bop)
                2'd0:    return a & b;
                2'd1:    return a | b;
                default: return a ^ b;
            endcase
        end else begin
            return 8'h00;
        end
    endfunction

    // Latency-1 ALU model
    always @(posedge clk) begin
        if (ALU_en) C <= alu_f(A, B, a_en, b_en, a_op, b_op);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [7:0] a, input logic [7:0] b, input logic aen,
                           input logic ben, input logic [2:0] aop, input logic [1:0] bop);
        cmd_A     = a;
        cmd_B     = b;
        cmd_a_en  = aen;
        cmd_b_en  = ben;
        cmd_a_op  = aop;
        cmd_b_op  = bop;
        cmd_valid = 1'b1;
    endtask

    // Offer 8 adds (F8+i)+4 with res_ready low, then idle 3 cycles
    task automatic fill_stall(output int acc, output int iss);
        int cyc;
        logic rdy;
        acc = 0;
        iss = 0;
        cyc = 0;
        while (acc < 8 && cyc < 40) begin
            set_cmd(8'(8'hF8 + acc), 8'h04, 1'b1, 1'b0, 3'd0, 2'd0);
            rdy = cmd_ready;
            tick();
            cyc++;
            if (ALU_en) iss++;
            if (rdy) acc++;
        end
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (ALU_en) iss++;
        end
    endtask

    initial begin
        int acc;
        int iss;
        int idx;
        int cyc;
        int got;
        int pushed;
        logic rdy;

        rst = 1'b1;
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        cmd_A = 8'h00; cmd_B = 8'h00;
        cmd_a_en = 1'b0; cmd_b_en = 1'b0; cmd_a_op = 3'd0; cmd_b_op = 2'd0;
        tick();
        tick();
        chk("rst_alu_en", ALU_en, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_A", A, 8'h00);
        rst = 1'b0;
        tick();

        // Single op 5+3
        set_cmd(8'h05, 8'h03, 1'b1, 1'b0, 3'd0, 2'd0);
        tick();
        cmd_valid = 1'b0;
        chk("single_accept_no_issue", ALU_en, 1'b0);
        chk("single_busy", busy, 1'b1);
        tick();
        chk("single_alu_en", ALU_en, 1'b1);
        chk("single_A", A, 8'h05);
        chk("single_B", B, 8'h03);
        tick();
        chk("single_alu_en_low", ALU_en, 1'b0);
        chk("single_A_hold", A, 8'h05);
        chk("single_not_yet_valid", res_valid, 1'b0);
        tick();
        chk("single_res_valid", res_valid, 1'b1);
        chk("single_res_data", res_data, 8'h08);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("single_popped", res_valid, 1'b0);
        chk("single_idle", busy, 1'b0);

        // Four back-to-back ops, consumer always ready
        res_ready = 1'b1;
        set_cmd(8'h0A, 8'h04, 1'b1, 1'b0, 3'd1, 2'd0);
        tick();
        chk("b2b_c0", ALU_en, 1'b0);
        set_cmd(8'hF0, 8'h3C, 1'b0, 1'b1, 3'd0, 2'd0);
        tick();
        chk("b2b_c1_en", ALU_en, 1'b1);
        chk("b2b_c1_A", A, 8'h0A);
        set_cmd(8'hF0, 8'h0F, 1'b0, 1'b1, 3'd0, 2'd1);
        tick();
        chk("b2b_c2_en", ALU_en, 1'b1);
        chk("b2b_c2_B", B, 8'h3C);
        set_cmd(8'hFF, 8'h02, 1'b1, 1'b0, 3'd0, 2'd0);
        tick();
        chk("b2b_c3_en", ALU_en, 1'b1);
        chk("b2b_c3_B", B, 8'h0F);
        chk("b2b_r0", res_data, 8'h06);
        cmd_valid = 1'b0;
        tick();
        chk("b2b_c4_en", ALU_en, 1'b1);
        chk("b2b_c4_A", A, 8'hFF);
        chk("b2b_r1", res_data, 8'h30);
        tick();
        chk("b2b_c5_en", ALU_en, 1'b0);
        chk("b2b_r2", res_data, 8'hFF);
        tick();
        chk("b2b_r3", res_data, 8'h01);
        tick();
        chk("b2b_empty", res_valid, 1'b0);
        res_ready = 1'b0;

        // Backpressure: credits limit issue to RES_DEPTH
        fill_stall(acc, iss);
        chk("stall_accepted", acc, 8);
        chk("stall_issues", iss, 4);
        chk("stall_alu_en", ALU_en, 1'b0);
        chk("stall_cmd_ready", cmd_ready, 1'b0);
        chk("stall_busy", busy, 1'b1);
        chk("stall_head", res_data, 8'hFC);
        res_ready = 1'b1;
        tick();
        chk("resume_wait", ALU_en, 1'b0);
        chk("resume_head", res_data, 8'hFD);
        tick();
        chk("resume_issue", ALU_en, 1'b1);
        chk("resume_A", A, 8'hFC);
        idx = 2;
        cyc = 0;
        while (idx < 8 && cyc < 60) begin
            if (res_valid) begin
                chk("wrap_order", res_data, 8'(8'hFC + idx));
                idx++;
            end
            tick();
            cyc++;
        end
        chk("wrap_count", idx, 8);
        tick();
        tick();
        chk("wrap_drained", res_valid, 1'b0);
        chk("wrap_idle", busy, 1'b0);
        res_ready = 1'b0;

        // Reset with 3 queued and 1 in flight
        fill_stall(acc, iss);
        chk("pre_rst_issues", iss, 4);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        chk("pre_rst_inflight", ALU_en, 1'b1);
        chk("pre_rst_ready", cmd_ready, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid_rst_alu_en", ALU_en, 1'b0);
        chk("mid_rst_res_valid", res_valid, 1'b0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("post_rst_no_result", res_valid, 1'b0);
        chk("post_rst_no_issue", ALU_en, 1'b0);
        chk("post_rst_busy", busy, 1'b0);

        // Five streamed ops with results returned in order
        res_ready = 1'b1;
        got = 0;
        pushed = 0;
        cyc = 0;
        while (got < 5 && cyc < 40) begin
            if (pushed < 5) begin
                set_cmd(8'(pushed + 1), 8'(pushed + 1), 1'b1, 1'b0, 3'd0, 2'd0);
            end else begin
                cmd_valid = 1'b0;
            end
            if (res_valid) begin
                chk("stream_order", res_data, 8'(2 * (got + 1)));
                got++;
            end
            rdy = cmd_ready && cmd_valid;
            tick();
            cyc++;
            if (rdy) pushed++;
        end
        cmd_valid = 1'b0;
        chk("stream_count", got, 5);
        tick();
        chk("stream_idle", busy, 1'b0);
`ifdef ALU_SEQ_STATS_EN
        chk("stat_issued", stat_issued, 16'd5);
        chk("stat_completed", stat_completed, 16'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
